mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM pipeline stage. Sits directly downstream of the EX/MEM register and consumes its outputs: ALU result, memory controls, MemtoReg, RegWr, destination register, PC+4.
- Performs the data-memory access over a req/ack handshake, stalls upstream while the access is outstanding, and registers the write-back result into the MEM/WB pipeline register.
- Watchdog counter and alignment check; sticky error on fault.

Parameters:
- DW, 32, data/address width
- TIMEOUT, 16, max cycles waiting for dmem_ack_i before fault (≥1)
- CW, $clog2(TIMEOUT+1), watchdog counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
- valid_i  in  1  EX/MEM slot holds a real instruction
- alu_res_i  in  DW  ALU result / memory address
- wr_data_i  in  DW  store data
- mem_rd_i  in  1  load
- mem_wr_i  in  1  store
- memto_reg_i  in  2  00 ALU, 01 mem, 10 PC+4, 11 ALU
- reg_wr_i  in  1  register write enable
- wr_reg_i  in  5  destination register
- pc_plus4_i  in  DW  link value
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  DW  word-aligned byte address
- dmem_wdata_o  out  DW  write data
- dmem_rdata_i  in  DW  read data, valid when dmem_ack_i=1
- dmem_ack_i  in  1  access complete (same-cycle allowed)
- stall_o  out  1  freeze EX/MEM and earlier stages
- err_o  out  1  sticky fault (timeout or misalignment)
- valid_o  out  1  MEM/WB valid
- wb_data_o  out  DW  write-back value
- wb_reg_o  out  5  write-back register
- reg_wr_o  out  1  write-back enable (already gated by valid)

Behaviour:
- mem_op = valid_i & (mem_rd_i | mem_wr_i).
- mis = mem_op & (alu_res_i[1:0] != 0).
- States: IDLE, WAIT, ERR.
- Combinational outputs:
  - dmem_req_o = mem_op & ~mis & (state != ERR).
  - dmem_we_o = mem_wr_i.
  - dmem_addr_o = alu_res_i.
  - dmem_wdata_o = wr_data_i.
  - stall_o = (state==ERR) | mis | (dmem_req_o & ~dmem_ack_i).
  - err_o = (state==ERR).
- Upstream holds all *_i stable while stall_o=1. A request is never retracted before ack.
- FSM and watchdog:
  - IDLE: if mis → ERR. Else if dmem_req_o & ~dmem_ack_i → WAIT, cnt<=1. Else stay.
  - WAIT: if dmem_ack_i → IDLE, cnt<=0. Else if cnt==TIMEOUT → ERR. Else cnt<=cnt+1.
  - ERR: absorbing until reset. No requests; permanent stall.
  - Zero-wait ack (ack in the request cycle) completes without entering WAIT: one access per instruction, no stall cycle.
- MEM/WB register (posedge clk):
  - If stall_o=1: insert bubble. valid_o<=0, reg_wr_o<=0; wb_data_o and wb_reg_o hold.
  - Else: valid_o<=valid_i; reg_wr_o<=valid_i & reg_wr_i; wb_reg_o<=wr_reg_i.
  - wb_data_o <= memto_reg_i==01 ? dmem_rdata_i : memto_reg_i==10 ? pc_plus4_i : alu_res_i.
  - Load result is captured in the ack cycle; write-back latency is 1 cycle after ack.
- Store: wb_data_o is whatever memto_reg_i selects. reg_wr_o follows reg_wr_i.
- Reset (reset==0 at posedge, overrides everything including mid-WAIT):
  - state=IDLE, cnt=0.
  - valid_o=0, reg_wr_o=0, wb_data_o=0, wb_reg_o=0.
  - Combinational outputs follow their equations with state=IDLE.
  - An outstanding external access is abandoned. The memory side must tolerate a dropped req.
- Bubble input (valid_i=0): no request, no stall, valid_o<=0 next cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - MemtoReg encodings MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC4=2'b10.
  - FSM state enum {IDLE, WAIT, ERR}.
  - DW default.
- One natural sub-module, mem_watchdog: counter with start/clear/expire, parameter TIMEOUT.
- Write-back mux and MEM/WB register stay inline.

Test Plan:
- Reset: hold reset=0 2 cycles with valid_i=1, mem_rd_i=1 → valid_o=0, reg_wr_o=0, wb_data_o=0, err_o=0; dmem_req_o follows inputs combinationally.
- Zero-wait load: alu_res_i=0x100, mem_rd_i=1, memto_reg_i=01, wr_reg_i=5, ack same cycle with rdata=0xDEADBEEF → stall_o never 1; next cycle valid_o=1, reg_wr_o=1, wb_reg_o=5, wb_data_o=0xDEADBEEF.
- 3-wait store: alu_res_i=0x204, wr_data_i=0x12345678, ack on 4th request cycle → stall_o=1 for 3 cycles, MEM/WB bubbles (valid_o=0) during the stall, dmem_we_o=1 and addr/data stable throughout; exactly one ack-cycle completion.
- Non-memory paths: memto_reg_i=10, pc_plus4_i=0x400008 → wb_data_o=0x400008, no dmem_req_o. memto_reg_i=00, alu_res_i=7 → wb_data_o=7.
- Faults, checked separately:
  - Misaligned: load at 0x102 → err_o=1 next cycle, dmem_req_o never asserted, stall_o stays 1.
  - Timeout: TIMEOUT=4, ack never arrives → err_o=1 after the 4th WAIT cycle.
  - Reset mid-WAIT: returns to IDLE, err_o=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data width default, MemtoReg encodings, MEM-stage FSM states.
package pipeline_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter for an outstanding data-memory access; flags when the limit is reached.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  logic [CW-1:0] cnt;

  // Counter: clear wins, start loads one (first wait cycle), run increments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_c = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage: data-memory access over req/ack, upstream stall, watchdog and
// alignment fault detection, and the MEM/WB pipeline register.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [DW-1:0] alu_res_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          mem_rd_i,
  input  logic          mem_wr_i,
  input  logic [1:0]    memto_reg_i,
  input  logic          reg_wr_i,
  input  logic [4:0]    wr_reg_i,
  input  logic [DW-1:0] pc_plus4_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  input  logic [DW-1:0] dmem_rdata_i,
  input  logic          dmem_ack_i,
  output logic          stall_o,
  output logic          err_o,
  output logic          valid_o,
  output logic [DW-1:0] wb_data_o,
  output logic [4:0]    wb_reg_o,
  output logic          reg_wr_o
);

  mem_state_e    state;
  logic          mem_op;
  logic          mis;
  logic          wd_start;
  logic          wd_clear;
  logic          wd_run;
  logic          wd_expired;
  logic [DW-1:0] wb_sel;

  assign mem_op = valid_i & (mem_rd_i | mem_wr_i);
  assign mis    = mem_op & (alu_res_i[1:0] != 2'b00);

  assign dmem_req_o   = mem_op & ~mis & (state != ERR);
  assign dmem_we_o    = mem_wr_i;
  assign dmem_addr_o  = alu_res_i;
  assign dmem_wdata_o = wr_data_i;
  assign stall_o      = (state == ERR) | mis | (dmem_req_o & ~dmem_ack_i);
  assign err_o        = (state == ERR);

  // Access FSM: ERR is absorbing until reset; a same-cycle ack never enters WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mis) begin
            state <= ERR;
          end else if (dmem_req_o && !dmem_ack_i) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            state <= IDLE;
          end else if (wd_expired) begin
            state <= ERR;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog controls derived from the current state and handshake.
  always_comb begin
    wd_start = 1'b0;
    wd_clear = 1'b0;
    wd_run   = 1'b0;
    case (state)
      IDLE: wd_start = ~mis & dmem_req_o & ~dmem_ack_i;
      WAIT: begin
        wd_clear = dmem_ack_i;
        wd_run   = ~dmem_ack_i & ~wd_expired;
      end
      default: ;
    endcase
  end

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .start     (wd_start),
    .clear     (wd_clear),
    .run       (wd_run),
    .expired_c (wd_expired)
  );

  // Write-back source select; MemtoReg 11 falls back to the ALU result.
  always_comb begin
    case (memto_reg_i)
      MTR_MEM: wb_sel = dmem_rdata_i;
      MTR_PC4: wb_sel = pc_plus4_i;
      default: wb_sel = alu_res_i;
    endcase
  end

  // MEM/WB register: a stall inserts a bubble and holds data/register fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_o   <= 1'b0;
      reg_wr_o  <= 1'b0;
      wb_data_o <= '0;
      wb_reg_o  <= '0;
    end else if (stall_o) begin
      valid_o  <= 1'b0;
      reg_wr_o <= 1'b0;
    end else begin
      valid_o   <= valid_i;
      reg_wr_o  <= valid_i & reg_wr_i;
      wb_reg_o  <= wr_reg_i;
      wb_data_o <= wb_sel;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with TIMEOUT=4.
module tb_mem_wb_stage;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          valid_i;
  logic [DW-1:0] alu_res_i;
  logic [DW-1:0] wr_data_i;
  logic          mem_rd_i;
  logic          mem_wr_i;
  logic [1:0]    memto_reg_i;
  logic          reg_wr_i;
  logic [4:0]    wr_reg_i;
  logic [DW-1:0] pc_plus4_i;
  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [DW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [DW-1:0] dmem_rdata_i;
  logic          dmem_ack_i;
  logic          stall_o;
  logic          err_o;
  logic          valid_o;
  logic [DW-1:0] wb_data_o;
  logic [4:0]    wb_reg_o;
  logic          reg_wr_o;

  int tests_run;
  int tests_failed;

  mem_wb_stage #(
    .DW      (DW),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .alu_res_i    (alu_res_i),
    .wr_data_i    (wr_data_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .memto_reg_i  (memto_reg_i),
    .reg_wr_i     (reg_wr_i),
    .wr_reg_i     (wr_reg_i),
    .pc_plus4_i   (pc_plus4_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .valid_o      (valid_o),
    .wb_data_o    (wb_data_o),
    .wb_reg_o     (wb_reg_o),
    .reg_wr_o     (reg_wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_i    = 1'b0;
    mem_rd_i   = 1'b0;
    mem_wr_i   = 1'b0;
    reg_wr_i   = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held with a load presented
    reset        = 1'b0;
    valid_i      = 1'b1;
    mem_rd_i     = 1'b1;
    mem_wr_i     = 1'b0;
    alu_res_i    = 32'h0000_0100;
    wr_data_i    = 32'h0;
    memto_reg_i  = 2'b01;
    reg_wr_i     = 1'b1;
    wr_reg_i     = 5'd5;
    pc_plus4_i   = 32'h0;
    dmem_rdata_i = 32'h0;
    dmem_ack_i   = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_reg_wr", 32'(reg_wr_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_wb_reg", 32'(wb_reg_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_req", 32'(dmem_req_o), 32'd1);
    check("rst_stall", 32'(stall_o), 32'd1);
    bubble();
    reset = 1'b1;
    tick();

    // Zero-wait load
    valid_i      = 1'b1;
    mem_rd_i     = 1'b1;
    alu_res_i    = 32'h0000_0100;
    memto_reg_i  = 2'b01;
    reg_wr_i     = 1'b1;
    wr_reg_i     = 5'd5;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("zw_req", 32'(dmem_req_o), 32'd1);
    check("zw_we", 32'(dmem_we_o), 32'd0);
    check("zw_stall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    check("zw_valid", 32'(valid_o), 32'd1);
    check("zw_reg_wr", 32'(reg_wr_o), 32'd1);
    check("zw_wb_reg", 32'(wb_reg_o), 32'd5);
    check("zw_wb_data", wb_data_o, 32'hDEAD_BEEF);
    #1;
    check("zw_no_stall_after", 32'(stall_o), 32'd0);

    // Store with three wait cycles
    valid_i     = 1'b1;
    mem_wr_i    = 1'b1;
    alu_res_i   = 32'h0000_0204;
    wr_data_i   = 32'h1234_5678;
    memto_reg_i = 2'b00;
    reg_wr_i    = 1'b0;
    wr_reg_i    = 5'd3;
    dmem_ack_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_stall", 32'(stall_o), 32'd1);
      check("st_req", 32'(dmem_req_o), 32'd1);
      check("st_we", 32'(dmem_we_o), 32'd1);
      check("st_addr", dmem_addr_o, 32'h0000_0204);
      check("st_wdata", dmem_wdata_o, 32'h1234_5678);
      tick();
      check("st_bubble", 32'(valid_o), 32'd0);
      check("st_err", 32'(err_o), 32'd0);
    end
    dmem_ack_i = 1'b1;
    #1;
    check("st_ack_stall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    check("st_done_valid", 32'(valid_o), 32'd1);
    check("st_done_reg_wr", 32'(reg_wr_o), 32'd0);
    check("st_done_wb_data", wb_data_o, 32'h0000_0204);
    check("st_done_wb_reg", 32'(wb_reg_o), 32'd3);
    tick();
    check("st_single_completion", 32'(valid_o), 32'd0);

    // PC+4 write-back, no memory access
    valid_i     = 1'b1;
    memto_reg_i = 2'b10;
    pc_plus4_i  = 32'h0040_0008;
    alu_res_i   = 32'h0000_0055;
    reg_wr_i    = 1'b1;
    wr_reg_i    = 5'd31;
    #1;
    check("pc4_req", 32'(dmem_req_o), 32'd0);
    check("pc4_stall", 32'(stall_o), 32'd0);
    tick();
    check("pc4_wb_data", wb_data_o, 32'h0040_0008);
    check("pc4_wb_reg", 32'(wb_reg_o), 32'd31);
    check("pc4_reg_wr", 32'(reg_wr_o), 32'd1);

    // ALU write-back, encodings 00 and 11
    memto_reg_i = 2'b00;
    alu_res_i   = 32'd7;
    wr_reg_i    = 5'd9;
    tick();
    check("alu_wb_data", wb_data_o, 32'd7);
    check("alu_wb_reg", 32'(wb_reg_o), 32'd9);
    memto_reg_i = 2'b11;
    alu_res_i   = 32'd9;
    tick();
    check("alu11_wb_data", wb_data_o, 32'd9);
    bubble();
    tick();
    check("bubble_valid", 32'(valid_o), 32'd0);
    check("bubble_reg_wr", 32'(reg_wr_o), 32'd0);

    // Misaligned load
    valid_i     = 1'b1;
    mem_rd_i    = 1'b1;
    alu_res_i   = 32'h0000_0102;
    memto_reg_i = 2'b01;
    reg_wr_i    = 1'b1;
    #1;
    check("mis_req", 32'(dmem_req_o), 32'd0);
    check("mis_stall", 32'(stall_o), 32'd1);
    tick();
    check("mis_err", 32'(err_o), 32'd1);
    check("mis_valid", 32'(valid_o), 32'd0);
    check("mis_req_after", 32'(dmem_req_o), 32'd0);
    tick();
    check("mis_stall_sticky", 32'(stall_o), 32'd1);
    check("mis_err_sticky", 32'(err_o), 32'd1);
    bubble();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mis_reset_err", 32'(err_o), 32'd0);
    tick();

    // Timeout: ack never arrives
    valid_i   = 1'b1;
    mem_rd_i  = 1'b1;
    alu_res_i = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_err_early", 32'(err_o), 32'd0);
      check("to_req_held", 32'(dmem_req_o), 32'd1);
    end
    tick();
    check("to_err", 32'(err_o), 32'd1);
    check("to_req_dropped", 32'(dmem_req_o), 32'd0);
    check("to_stall", 32'(stall_o), 32'd1);
    bubble();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("to_reset_err", 32'(err_o), 32'd0);
    tick();

    // Reset during WAIT
    valid_i   = 1'b1;
    mem_rd_i  = 1'b1;
    alu_res_i = 32'h0000_0310;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bubble();
    #1;
    check("rw_err", 32'(err_o), 32'd0);
    check("rw_stall", 32'(stall_o), 32'd0);
    tick();
    // Back in IDLE: a zero-wait load completes immediately
    valid_i      = 1'b1;
    mem_rd_i     = 1'b1;
    alu_res_i    = 32'h0000_0320;
    memto_reg_i  = 2'b01;
    reg_wr_i     = 1'b1;
    wr_reg_i     = 5'd12;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    #1;
    check("rw_zw_stall", 32'(stall_o), 32'd0);
    tick();
    bubble();
    check("rw_zw_valid", 32'(valid_o), 32'd1);
    check("rw_zw_wb_data", wb_data_o, 32'hCAFE_F00D);
    check("rw_zw_wb_reg", 32'(wb_reg_o), 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
